// File: rtl/lua_operand_fetch.sv
// Lua 5.3 decode and operand-fetch stage: resolves RK(B)/RK(C) and reads their TValues over Avalon-MM.
// Build option LUA_OPFETCH_NEEDMASK_EN: fetch only the operands the opcode actually uses.
module lua_operand_fetch #(
  parameter int TVALUE_SHIFT = 3
) (
  input  logic        main_clk,
  input  logic        main_rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_base,
  input  logic [31:0] in_k,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_ra_addr,
  output logic [31:0] out_rb_val,
  output logic [31:0] out_rb_tag,
  output logic [31:0] out_rc_val,
  output logic [31:0] out_rc_tag,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RB_VAL,
    S_RB_TAG,
    S_RC_VAL,
    S_RC_TAG,
    S_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] base_q, base_d;
  logic [31:0] k_q, k_d;
  logic [31:0] rb_val_q, rb_val_d;
  logic [31:0] rb_tag_q, rb_tag_d;
  logic [31:0] rc_val_q, rc_val_d;
  logic [31:0] rc_tag_q, rc_tag_d;

  logic        need_b_in;
  logic        need_c_in;
  logic        need_c_cur;
  logic [31:0] addr_b;
  logic [31:0] addr_c;

  // Constant-table operands use only the low 8 bits of the field; register operands use all 9.
  function automatic logic [31:0] rk_addr(input logic [8:0] x, input logic [31:0] base,
                                          input logic [31:0] k);
    if (x[8]) return k + ({24'd0, x[7:0]} << TVALUE_SHIFT);
    return base + ({23'd0, x} << TVALUE_SHIFT);
  endfunction

`ifdef LUA_OPFETCH_NEEDMASK_EN
  function automatic logic need_b_f(input logic [5:0] op);
    return (op == 6'd0) || (op == 6'd7) || (op == 6'd8) || (op == 6'd10) || (op == 6'd12) ||
           ((op >= 6'd13) && (op <= 6'd27)) || ((op >= 6'd31) && (op <= 6'd33));
  endfunction

  function automatic logic need_c_f(input logic [5:0] op);
    return (op == 6'd6) || (op == 6'd7) || (op == 6'd8) || (op == 6'd10) || (op == 6'd12) ||
           ((op >= 6'd13) && (op <= 6'd24)) || ((op >= 6'd31) && (op <= 6'd33));
  endfunction

  assign need_b_in  = need_b_f(in_instr[5:0]);
  assign need_c_in  = need_c_f(in_instr[5:0]);
  assign need_c_cur = need_c_f(instr_q[5:0]);
`else
  assign need_b_in  = 1'b1;
  assign need_c_in  = 1'b1;
  assign need_c_cur = 1'b1;
`endif

  assign addr_b      = rk_addr(instr_q[31:23], base_q, k_q);
  assign addr_c      = rk_addr(instr_q[22:14], base_q, k_q);
  assign out_ra_addr = base_q + ({24'd0, instr_q[13:6]} << TVALUE_SHIFT);

  // Reset gates in_ready directly so the block never looks ready while held in reset.
  assign in_ready   = (state_q == S_IDLE) && !main_rst;
  assign out_valid  = (state_q == S_OUT);
  assign out_instr  = instr_q;
  assign out_rb_val = rb_val_q;
  assign out_rb_tag = rb_tag_q;
  assign out_rc_val = rc_val_q;
  assign out_rc_tag = rc_tag_q;

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    base_d      = base_q;
    k_d         = k_q;
    rb_val_d    = rb_val_q;
    rb_tag_d    = rb_tag_q;
    rc_val_d    = rc_val_q;
    rc_tag_d    = rc_tag_q;
    avm_read    = 1'b0;
    avm_address = '0;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          instr_d  = in_instr;
          base_d   = in_base;
          k_d      = in_k;
          rb_val_d = '0;
          rb_tag_d = '0;
          rc_val_d = '0;
          rc_tag_d = '0;
          if (need_b_in)      state_d = S_RB_VAL;
          else if (need_c_in) state_d = S_RC_VAL;
          else                state_d = S_OUT;
        end
      end
      S_RB_VAL: begin
        avm_read    = 1'b1;
        avm_address = addr_b;
        if (!avm_waitrequest) begin
          rb_val_d = avm_readdata;
          state_d  = S_RB_TAG;
        end
      end
      S_RB_TAG: begin
        avm_read    = 1'b1;
        avm_address = addr_b + 32'd4;
        if (!avm_waitrequest) begin
          rb_tag_d = avm_readdata;
          state_d  = need_c_cur ? S_RC_VAL : S_OUT;
        end
      end
      S_RC_VAL: begin
        avm_read    = 1'b1;
        avm_address = addr_c;
        if (!avm_waitrequest) begin
          rc_val_d = avm_readdata;
          state_d  = S_RC_TAG;
        end
      end
      S_RC_TAG: begin
        avm_read    = 1'b1;
        avm_address = addr_c + 32'd4;
        if (!avm_waitrequest) begin
          rc_tag_d = avm_readdata;
          state_d  = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge main_clk or posedge main_rst) begin
    if (main_rst) begin
      state_q  <= S_IDLE;
      instr_q  <= '0;
      base_q   <= '0;
      k_q      <= '0;
      rb_val_q <= '0;
      rb_tag_q <= '0;
      rc_val_q <= '0;
      rc_tag_q <= '0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      base_q   <= base_d;
      k_q      <= k_d;
      rb_val_q <= rb_val_d;
      rb_tag_q <= rb_tag_d;
      rc_val_q <= rc_val_d;
      rc_tag_q <= rc_tag_d;
    end
  end

endmodule

// File: tb/tb_lua_operand_fetch.sv
// Scoreboard bench for lua_operand_fetch: a bus model serves reads at negedges, expected
// read addresses and operand bundles are queued when each instruction is driven.
module tb_lua_operand_fetch;

  logic        main_clk = 1'b0;
  logic        main_rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_base = '0;
  logic [31:0] in_k = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_ra_addr;
  logic [31:0] out_rb_val;
  logic [31:0] out_rb_tag;
  logic [31:0] out_rc_val;
  logic [31:0] out_rc_tag;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] ra;
    logic [31:0] rbv;
    logic [31:0] rbt;
    logic [31:0] rcv;
    logic [31:0] rct;
    int          lat;
  } bundle_t;

  bundle_t     exp_q[$];
  logic [31:0] addr_q[$];

  // Opcode bitmaps of which operands get fetched; all ones when every opcode fetches both.
`ifdef LUA_OPFETCH_NEEDMASK_EN
  localparam logic [63:0] NEED_B_MASK = 64'h0000_0003_8FFF_F581;
  localparam logic [63:0] NEED_C_MASK = 64'h0000_0003_81FF_F5C0;
`else
  localparam logic [63:0] NEED_B_MASK = '1;
  localparam logic [63:0] NEED_C_MASK = '1;
`endif

  lua_operand_fetch dut (
    .main_clk       (main_clk),
    .main_rst       (main_rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_base        (in_base),
    .in_k           (in_k),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_ra_addr    (out_ra_addr),
    .out_rb_val     (out_rb_val),
    .out_rb_tag     (out_rb_tag),
    .out_rc_val     (out_rc_val),
    .out_rc_tag     (out_rc_tag),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  always #5 main_clk = ~main_clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] model_rk(input logic [8:0] x, input logic [31:0] base,
                                           input logic [31:0] k);
    if (x[8]) return k + 32'(x[7:0]) * 32'd8;
    return base + 32'(x) * 32'd8;
  endfunction

  function automatic logic [31:0] make_instr(input int b, input int c, input int a, input int op);
    logic [31:0] w;
    w = {b[8:0], c[8:0], a[7:0], op[5:0]};
    return w;
  endfunction

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Queues the expected reads and bundle, then presents the instruction until it is accepted.
  task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] base,
                               input logic [31:0] k, input int waits);
    bundle_t     b;
    logic [31:0] ab;
    logic [31:0] ac;
    int          nreads;
    ab     = model_rk(instr[31:23], base, k);
    ac     = model_rk(instr[22:14], base, k);
    b      = '{instr: instr, ra: base + 32'(instr[13:6]) * 32'd8,
               rbv: '0, rbt: '0, rcv: '0, rct: '0, lat: 0};
    nreads = 0;
    if (NEED_B_MASK[instr[5:0]]) begin
      addr_q.push_back(ab);
      addr_q.push_back(ab + 32'd4);
      b.rbv  = mem_word(ab);
      b.rbt  = mem_word(ab + 32'd4);
      nreads += 2;
    end
    if (NEED_C_MASK[instr[5:0]]) begin
      addr_q.push_back(ac);
      addr_q.push_back(ac + 32'd4);
      b.rcv  = mem_word(ac);
      b.rct  = mem_word(ac + 32'd4);
      nreads += 2;
    end
    b.lat = 1 + nreads * (1 + waits);
    exp_q.push_back(b);

    @(negedge main_clk);
    in_valid = 1'b1;
    in_instr = instr;
    in_base  = base;
    in_k     = k;
    expect_eq("in_ready_idle", in_ready, 1'b1);
    expect_eq("avm_read_idle", avm_read, 1'b0);
    @(posedge main_clk);
    @(negedge main_clk);
    in_valid = 1'b0;
  endtask

  // Pops the expected bundle, checks it, optionally stalls out_ready, then completes the handshake.
  task automatic checkOutput(input int lat, input int hold);
    bundle_t b;
    b = exp_q.pop_front();
    expect_eq("latency", lat, b.lat);
    expect_eq("reads_left", addr_q.size(), 0);
    expect_eq("out_instr", out_instr, b.instr);
    expect_eq("out_ra_addr", out_ra_addr, b.ra);
    expect_eq("out_rb_val", out_rb_val, b.rbv);
    expect_eq("out_rb_tag", out_rb_tag, b.rbt);
    expect_eq("out_rc_val", out_rc_val, b.rcv);
    expect_eq("out_rc_tag", out_rc_tag, b.rct);
    expect_eq("in_ready_busy", in_ready, 1'b0);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      @(posedge main_clk);
      @(negedge main_clk);
      expect_eq("hold_out_valid", out_valid, 1'b1);
      expect_eq("hold_in_ready", in_ready, 1'b0);
      expect_eq("hold_rb_val", out_rb_val, b.rbv);
      expect_eq("hold_rc_tag", out_rc_tag, b.rct);
      expect_eq("hold_ra_addr", out_ra_addr, b.ra);
    end
    out_ready = 1'b1;
    @(posedge main_clk);
    @(negedge main_clk);
    out_ready = 1'b0;
    expect_eq("in_ready_after_hs", in_ready, 1'b1);
    expect_eq("out_valid_after_hs", out_valid, 1'b0);
  endtask

  // Acts as the Avalon slave, inserting `waits` stall cycles before accepting each read.
  task automatic serviceBus(input int waits, input int hold);
    int          lat;
    int          wait_left;
    bit          done;
    bit          stalling;
    logic [31:0] stall_addr;
    logic [31:0] exp_addr;
    lat        = 1;
    wait_left  = waits;
    done       = 1'b0;
    stalling   = 1'b0;
    stall_addr = '0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (out_valid) begin
        done = 1'b1;
      end else begin
        avm_waitrequest = 1'b0;
        if (avm_read) begin
          if (wait_left > 0) begin
            avm_waitrequest = 1'b1;
            if (stalling) expect_eq("stall_addr_held", avm_address, stall_addr);
            stall_addr = avm_address;
            stalling   = 1'b1;
            wait_left--;
          end else begin
            if (stalling) expect_eq("release_addr_held", avm_address, stall_addr);
            stalling     = 1'b0;
            avm_readdata = mem_word(avm_address);
            exp_addr     = (addr_q.size() == 0) ? ~avm_address : addr_q.pop_front();
            expect_eq("read_addr", avm_address, exp_addr);
            wait_left    = waits;
          end
        end
        @(posedge main_clk);
        @(negedge main_clk);
        lat++;
      end
    end
    avm_waitrequest = 1'b0;
    expect_eq("out_valid_timeout", done, 1'b1);
    if (done) checkOutput(lat, hold);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] instr;
    logic [31:0] exp_c;

    // Reset values.
    repeat (2) @(negedge main_clk);
    expect_eq("rst_in_ready", in_ready, 1'b0);
    expect_eq("rst_out_valid", out_valid, 1'b0);
    expect_eq("rst_avm_read", avm_read, 1'b0);
    expect_eq("rst_avm_address", avm_address, 32'd0);
    expect_eq("rst_out_instr", out_instr, 32'd0);
    expect_eq("rst_out_ra_addr", out_ra_addr, 32'd0);
    expect_eq("rst_out_rb_val", out_rb_val, 32'd0);
    expect_eq("rst_out_rc_tag", out_rc_tag, 32'd0);
    main_rst = 1'b0;
    #1;
    expect_eq("post_rst_in_ready", in_ready, 1'b1);

    // ADD A=2 B=3 C=K[1]: reads 0x1018/0x101C/0x2008/0x200C, RA at 0x1010.
    instr = make_instr(3, 'h101, 2, 13);
    applyStimulus(instr, 32'h0000_1000, 32'h0000_2000, 0);
    serviceBus(0, 0);

    // JMP: operand fetch depends on the build option.
    applyStimulus(make_instr(5, 6, 1, 30), 32'h0000_3000, 32'h0000_5000, 0);
    serviceBus(0, 0);

    // GETTABLE with three stall cycles on every read.
    applyStimulus(make_instr(4, 'h1FF, 9, 7), 32'h0000_4000, 32'h0000_8000, 3);
    serviceBus(3, 0);

    // Execute stage holds off for ten cycles.
    applyStimulus(make_instr('h120, 17, 200, 12), 32'h0001_0000, 32'h0002_0000, 0);
    serviceBus(0, 10);

    // Register-base wrap: B reads land at 0x0 and 0x4.
    applyStimulus(make_instr(1, 0, 0, 0), 32'hFFFF_FFF8, 32'h0000_0100, 0);
    serviceBus(0, 0);

    // Reset while the RC value read is outstanding.
    instr = make_instr(2, 3, 4, 13);
    exp_c = model_rk(instr[22:14], 32'h0000_6000, 32'h0000_7000);
    @(negedge main_clk);
    in_valid = 1'b1;
    in_instr = instr;
    in_base  = 32'h0000_6000;
    in_k     = 32'h0000_7000;
    @(posedge main_clk);
    @(negedge main_clk);
    in_valid = 1'b0;
    repeat (2) @(negedge main_clk);
    expect_eq("rcval_avm_read", avm_read, 1'b1);
    expect_eq("rcval_avm_address", avm_address, exp_c);
    #2;
    main_rst = 1'b1;
    #1;
    expect_eq("midrst_avm_read", avm_read, 1'b0);
    expect_eq("midrst_out_valid", out_valid, 1'b0);
    expect_eq("midrst_in_ready", in_ready, 1'b0);
    @(negedge main_clk);
    main_rst = 1'b0;
    #1;
    expect_eq("midrst_release_in_ready", in_ready, 1'b1);
    applyStimulus(make_instr('h1AB, 'h0CD, 77, 31), 32'h0000_9000, 32'h000A_0000, 1);
    serviceBus(1, 2);

    // Randomised bundles with mixed stall lengths.
    for (int i = 0; i < 6; i++) begin
      int w;
      w = $urandom_range(0, 2);
      applyStimulus($urandom, $urandom, $urandom, w);
      serviceBus(w, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lua_operand_fetch.md
# lua_operand_fetch

Decode-and-operand-fetch stage placed directly downstream of the Lua instruction fetch unit. It accepts one fetched 32-bit Lua 5.3 instruction together with the frame's stack base and constant-table pointer. It decodes the instruction, resolves the RK(B)/RK(C) operands to addresses, reads their 8-byte TValues (value word, tag word) over an Avalon-MM read master, and hands a complete operand bundle to the execute stage through a valid/ready handshake.

## Interface
- TVALUE_SHIFT, 3: log2 of TValue size in bytes (8-byte TValue: value word at +0, tag word at +4).
- main_clk  in  1  clock; every register in the block is clocked by it.
- main_rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream instruction bundle valid.
- in_ready  out  1  block can accept a bundle; high only in IDLE.
- in_instr  in  32  instruction: op[5:0], A[13:6], C[22:14], B[31:23].
- in_base  in  32  byte address of stack register 0.
- in_k  in  32  byte address of constant 0.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  execute stage consumes the bundle.
- out_instr  out  32  captured instruction.
- out_ra_addr  out  32  in_base + (A << TVALUE_SHIFT).
- out_rb_val, out_rb_tag  out  32 each  RK(B) TValue words; 0 when not fetched.
- out_rc_val, out_rc_tag  out  32 each  RK(C) TValue words; 0 when not fetched.
- avm_address  out  32  read byte address.
- avm_read  out  1  read request.
- avm_readdata  in  32  read data, valid in the cycle avm_waitrequest is low.
- avm_waitrequest  in  1  stall; the request is held unchanged while high.

## Operation
- RK decode for a 9-bit field x: if x[8]=1, the address is in_k + (x[7:0] << TVALUE_SHIFT); otherwise it is in_base + (x << TVALUE_SHIFT). All address arithmetic is 32-bit, modulo 2^32 (wraps without error).
- need_b: op ∈ {0, 7, 8, 10, 12, 13–27, 31–33}.
- need_c: op ∈ {6, 7, 8, 10, 12, 13–24, 31–33}.
- States: IDLE, RB_VAL, RB_TAG, RC_VAL, RC_TAG, OUT.
- IDLE: in_ready=1. On in_valid, capture instr/base/k and clear operand registers. Next state is RB_VAL if need_b, else RC_VAL if need_c, else OUT.
- RB_VAL → RB_TAG: read address addrB, then addrB+4.
- RB_TAG exits to RC_VAL if need_c, else to OUT.
- RC_VAL → RC_TAG → OUT: read address addrC, then addrC+4.
- Each read state drives avm_read=1 with its address. It advances and captures avm_readdata only in the cycle avm_waitrequest=0.
- OUT: out_valid=1 with all outputs stable. When out_ready=1, go to IDLE.

## Timing
- Reset values: in_ready=0 during reset (1 after reset in IDLE), out_valid=0, avm_read=0, avm_address=0, all out_* data=0.
- Reset mid-read drops avm_read asynchronously; the in-flight bundle is discarded.
- Zero wait states, both operands needed: out_valid rises 5 cycles after the accept edge. With one operand it is 3 cycles; with none it is 1 cycle.
- Each waitrequest cycle adds one cycle to the latency.
- After the out_ready handshake, in_ready is high in the following cycle. There is no same-cycle turnaround.
- out_ready is ignored outside OUT. in_valid is ignored outside IDLE.
- At most one outstanding read at a time. avm_address changes only on an accepted read or a state change.

## Configuration
- LUA_OPFETCH_NEEDMASK_EN defined: fetch only the operands selected by need_b/need_c, as described above.
- LUA_OPFETCH_NEEDMASK_EN undefined: need_b=need_c=1 for every opcode. All four reads always occur, fixed 5-cycle minimum latency.

## Test plan
- ADD (op 13), A=2, B=3, C=0x101, base=0x1000, k=0x2000, zero wait:
  - reads occur at 0x1018, 0x101C, 0x2008, 0x200C;
  - out_ra_addr=0x1010;
  - out_valid 5 cycles after accept.
- JMP (op 30) with NEEDMASK_EN: no avm_read; out_valid 1 cycle after accept; operand outputs 0.
- JMP (op 30) without NEEDMASK_EN: four reads, out_valid after 5 cycles.
- GETTABLE (op 7) with 3 waitrequest cycles on each read: latency 5+12=17 cycles; avm_address is held stable during every stall.
- out_ready held low for 10 cycles in OUT: outputs unchanged, in_ready stays 0. Once out_ready=1, in_ready=1 next cycle.
- Reset asserted during RC_VAL: avm_read=0 and out_valid=0 immediately. After release, a new bundle is accepted normally.
- base=0xFFFFFFF8, B=1: B reads occur at 0x00000000 and 0x00000004 (address wrap).
